uart_fifo_controller: RTL and testbench

UART_FIFO_CONTROLLER -- requirements
Module: uart_fifo_controller

---
 rtl/uart_fifo_controller.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_uart_fifo_controller.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_controller.sv
//------------------------------------------------------------------------------
// Module      : uart_fifo_controller
// Description : Wishbone-mapped 8N1 UART with TX/RX FIFOs, sticky status, irq.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module uart_fifo_controller #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CLK_FREQ   = 80_000_000,
  parameter int BAUD       = 1152000,
  parameter int TX_DEPTH   = 16,
  parameter int RX_DEPTH   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  output logic                    wb_ack_o,
  output logic                    uart_txd_o,
  input  logic                    uart_rxd_i,
  output logic                    irq_o
);

  localparam int c_div   = CLK_FREQ / BAUD;
  localparam int c_cw    = $clog2(c_div);
  localparam int c_tx_aw = $clog2(TX_DEPTH);
  localparam int c_rx_aw = $clog2(RX_DEPTH);

  localparam logic [c_cw-1:0] c_bit_last  = c_cw'(c_div - 1);
  localparam logic [c_cw-1:0] c_half_last = c_cw'(c_div / 2 - 1);
  localparam logic [c_cw-1:0] c_cnt_one   = c_cw'(1);

  localparam logic [7:0] c_adr_data   = 8'h00;
  localparam logic [7:0] c_adr_status = 8'h04;
  localparam logic [7:0] c_adr_level  = 8'h08;
  localparam logic [7:0] c_adr_ctrl   = 8'h0C;

  typedef enum logic [0:0] {TX_IDLE, TX_SHIFT} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  logic                  r_ack;
  logic [DATA_WIDTH-1:0] r_dat;
  logic                  r_rx_irq_en, r_tx_irq_en;
  logic                  r_rx_overrun, r_frame_err, r_tx_overflow;
  logic                  r_irq;

  logic                  w_req;
  logic [7:0]            w_adr;
  logic                  w_ctrl_wr, w_flush, w_clear;
  logic [DATA_WIDTH-1:0] w_rd_val;
  logic                  w_unused;

  assign w_req     = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_adr     = wb_adr_i[7:0];
  assign w_ctrl_wr = w_req & wb_we_i & (w_adr == c_adr_ctrl) & wb_sel_i[0];
  assign w_flush   = w_ctrl_wr & wb_dat_i[3];
  assign w_clear   = w_ctrl_wr & wb_dat_i[2];
  assign w_unused  = ^{wb_adr_i[ADDR_WIDTH-1:8], wb_sel_i[DATA_WIDTH/8-1:1],
                       wb_dat_i[DATA_WIDTH-1:8]};

  // ---------------- TX FIFO ----------------
  logic [7:0]       r_tx_mem [TX_DEPTH];
  logic [c_tx_aw:0] r_tx_wptr, r_tx_rptr;
  logic [c_tx_aw:0] w_tx_level;
  logic             w_tx_empty, w_tx_full, w_tx_push, w_tx_push_req, w_tx_pop;
  logic [7:0]       w_tx_head;

  assign w_tx_level    = r_tx_wptr - r_tx_rptr;
  assign w_tx_empty    = (r_tx_wptr == r_tx_rptr);
  assign w_tx_full     = (r_tx_wptr[c_tx_aw] != r_tx_rptr[c_tx_aw]) &&
                         (r_tx_wptr[c_tx_aw-1:0] == r_tx_rptr[c_tx_aw-1:0]);
  assign w_tx_head     = r_tx_mem[r_tx_rptr[c_tx_aw-1:0]];
  assign w_tx_push_req = w_req & wb_we_i & (w_adr == c_adr_data) & wb_sel_i[0];
  assign w_tx_push     = w_tx_push_req & ~w_tx_full;

  always_ff @(posedge clk_i) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr[c_tx_aw-1:0]] <= wb_dat_i[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + (c_tx_aw+1)'(1);
      if (w_flush)       r_tx_rptr <= r_tx_wptr;
      else if (w_tx_pop) r_tx_rptr <= r_tx_rptr + (c_tx_aw+1)'(1);
    end
  end

  // ---------------- TX shifter ----------------
  tx_state_t       r_tx_state;
  logic [c_cw-1:0] r_tx_cnt;
  logic [3:0]      r_tx_bit;
  logic [7:0]      r_tx_shift;
  logic            r_txd;
  logic            w_tx_frame_end, w_tx_idle;

  // A new frame is loaded on the stop bit's last cycle so frames run back-to-back.
  assign w_tx_frame_end = (r_tx_state == TX_SHIFT) && (r_tx_cnt == '0) && (r_tx_bit == 4'd9);
  assign w_tx_pop       = ((r_tx_state == TX_IDLE) | w_tx_frame_end) & ~w_tx_empty;
  assign w_tx_idle      = w_tx_empty & (r_tx_state == TX_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_txd      <= 1'b1;
    end else if (w_tx_pop) begin
      r_tx_state <= TX_SHIFT;
      r_tx_cnt   <= c_bit_last;
      r_tx_bit   <= '0;
      r_tx_shift <= w_tx_head;
      r_txd      <= 1'b0;
    end else if (r_tx_state == TX_SHIFT) begin
      if (r_tx_cnt != '0) begin
        r_tx_cnt <= r_tx_cnt - c_cnt_one;
      end else if (r_tx_bit == 4'd9) begin
        r_tx_state <= TX_IDLE;
      end else begin
        r_tx_cnt <= c_bit_last;
        r_tx_bit <= r_tx_bit + 4'd1;
        if (r_tx_bit == 4'd8) begin
          r_txd <= 1'b1;
        end else begin
          r_txd      <= r_tx_shift[0];
          r_tx_shift <= {1'b0, r_tx_shift[7:1]};
        end
      end
    end
  end

  // ---------------- RX receiver ----------------
  rx_state_t       r_rx_state;
  logic            r_rx_s1, r_rx_s2, r_rx_prev;
  logic [c_cw-1:0] r_rx_cnt;
  logic [2:0]      r_rx_bit;
  logic [7:0]      r_rx_shift;
  logic            w_rx_done, w_rx_push_req, w_rx_ferr;

  assign w_rx_done     = (r_rx_state == RX_STOP) && (r_rx_cnt == '0);
  assign w_rx_push_req = w_rx_done & r_rx_s2;
  assign w_rx_ferr     = w_rx_done & ~r_rx_s2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_s1   <= uart_rxd_i;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_prev & ~r_rx_s2) begin
            r_rx_state <= RX_START;
            r_rx_cnt   <= c_half_last;
          end
        end
        RX_START: begin
          if (r_rx_cnt != '0) begin
            r_rx_cnt <= r_rx_cnt - c_cnt_one;
          end else if (r_rx_s2) begin
            r_rx_state <= RX_IDLE;
          end else begin
            r_rx_state <= RX_DATA;
            r_rx_cnt   <= c_bit_last;
            r_rx_bit   <= '0;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt != '0) begin
            r_rx_cnt <= r_rx_cnt - c_cnt_one;
          end else begin
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            r_rx_cnt   <= c_bit_last;
            r_rx_bit   <= r_rx_bit + 3'd1;
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (r_rx_cnt != '0) r_rx_cnt <= r_rx_cnt - c_cnt_one;
          else                r_rx_state <= r_rx_s2 ? RX_IDLE : RX_WAIT;
        end
        RX_WAIT: begin
          if (r_rx_s2) r_rx_state <= RX_IDLE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]       r_rx_mem [RX_DEPTH];
  logic [c_rx_aw:0] r_rx_wptr, r_rx_rptr;
  logic [c_rx_aw:0] w_rx_level;
  logic             w_rx_empty, w_rx_full, w_rx_push, w_rx_pop, w_rx_ovr;

  assign w_rx_level = r_rx_wptr - r_rx_rptr;
  assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
  assign w_rx_full  = (r_rx_wptr[c_rx_aw] != r_rx_rptr[c_rx_aw]) &&
                      (r_rx_wptr[c_rx_aw-1:0] == r_rx_rptr[c_rx_aw-1:0]);
  assign w_rx_pop   = w_req & ~wb_we_i & (w_adr == c_adr_data) & ~w_rx_empty;
  // A flush in the same cycle frees the slot, so the arriving byte survives it.
  assign w_rx_push  = w_rx_push_req & (~w_rx_full | w_rx_pop | w_flush);
  assign w_rx_ovr   = w_rx_push_req & w_rx_full & ~w_rx_pop & ~w_flush;

  always_ff @(posedge clk_i) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr[c_rx_aw-1:0]] <= r_rx_shift;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + (c_rx_aw+1)'(1);
      if (w_flush)       r_rx_rptr <= r_rx_wptr;
      else if (w_rx_pop) r_rx_rptr <= r_rx_rptr + (c_rx_aw+1)'(1);
    end
  end

  // ---------------- Register file ----------------
  always_comb begin
    w_rd_val = '0;
    case (w_adr)
      c_adr_data:   if (!w_rx_empty) w_rd_val[7:0] = r_rx_mem[r_rx_rptr[c_rx_aw-1:0]];
      c_adr_status: w_rd_val[6:0] = {w_tx_idle, ~w_tx_full, 1'b0, r_tx_overflow,
                                     r_frame_err, r_rx_overrun, ~w_rx_empty};
      c_adr_level:  w_rd_val[15:0] = {8'(w_tx_level), 8'(w_rx_level)};
      c_adr_ctrl:   w_rd_val[1:0] = {r_tx_irq_en, r_rx_irq_en};
      default:      w_rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ack         <= 1'b0;
      r_dat         <= '0;
      r_rx_irq_en   <= 1'b0;
      r_tx_irq_en   <= 1'b0;
      r_rx_overrun  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_tx_overflow <= 1'b0;
      r_irq         <= 1'b0;
    end else begin
      r_ack <= w_req;
      if (w_req) r_dat <= wb_we_i ? '0 : w_rd_val;
      if (w_ctrl_wr) begin
        r_rx_irq_en <= wb_dat_i[0];
        r_tx_irq_en <= wb_dat_i[1];
      end
      // New events in the clearing cycle win over the clear.
      r_rx_overrun  <= (r_rx_overrun  & ~w_clear) | w_rx_ovr;
      r_frame_err   <= (r_frame_err   & ~w_clear) | w_rx_ferr;
      r_tx_overflow <= (r_tx_overflow & ~w_clear) | (w_tx_push_req & w_tx_full);
      r_irq <= (r_rx_irq_en & ~w_rx_empty) | (r_tx_irq_en & w_tx_idle) |
               r_rx_overrun | r_frame_err;
    end
  end

  assign wb_ack_o   = r_ack;
  assign wb_dat_o   = r_dat;
  assign uart_txd_o = r_txd;
  assign irq_o      = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_uart_fifo_controller.sv
//------------------------------------------------------------------------------
// Module      : tb_uart_fifo_controller
// Description : Directed self-checking bench for uart_fifo_controller (DIV=8, depth 4).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_uart_fifo_controller;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i = 4'hF;
  logic        wb_ack_o, uart_txd_o, irq_o;
  logic        uart_rxd_i = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;
  logic [7:0] tx_q[$];
  int         tx_t[$];
  int         tx_bad_stop = 0;

  uart_fifo_controller #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .CLK_FREQ(800), .BAUD(100),
    .TX_DEPTH(4), .RX_DEPTH(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_sel_i(wb_sel_i), .wb_ack_o(wb_ack_o),
    .uart_txd_o(uart_txd_o), .uart_rxd_i(uart_rxd_i), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wb_xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] q);
    int k;
    @(posedge clk_i); #1;
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = w; wb_adr_i = {24'h0, a}; wb_dat_i = d; wb_sel_i = s;
    k = 0;
    do begin @(posedge clk_i); #1; k++; end while (wb_ack_o !== 1'b1 && k < 10);
    if (wb_ack_o !== 1'b1) check_val("wb_ack_timeout", {31'b0, wb_ack_o}, 32'h1);
    q = wb_dat_o;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
  endtask

  task automatic wb_write(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] q;
    wb_xfer(1'b1, a, d, 4'hF, q);
  endtask

  task automatic wb_read(input logic [7:0] a, output logic [31:0] q);
    wb_xfer(1'b0, a, 32'h0, 4'hF, q);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(posedge clk_i); #1; uart_rxd_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (8) @(posedge clk_i); #1; uart_rxd_i = b[i];
    end
    repeat (8) @(posedge clk_i); #1; uart_rxd_i = stop;
    repeat (8) @(posedge clk_i); #1; uart_rxd_i = 1'b1;
    repeat (4) @(posedge clk_i); #1;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (tx_q.size() < n && k < budget) begin @(posedge clk_i); k++; end
    #1;
  endtask

  // Line monitor: decodes every frame on uart_txd_o at bit centres.
  initial begin : mon
    logic [7:0] b;
    int t0;
    forever begin
      @(posedge clk_i); #1;
      if (rst_i === 1'b0 && uart_txd_o === 1'b0) begin
        t0 = cyc_cnt;
        repeat (4) @(posedge clk_i); #1;
        for (int i = 0; i < 8; i++) begin
          repeat (8) @(posedge clk_i); #1; b[i] = uart_txd_o;
        end
        repeat (8) @(posedge clk_i); #1;
        if (uart_txd_o !== 1'b1) tx_bad_stop++;
        tx_q.push_back(b);
        tx_t.push_back(t0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] rd;
    int n;

    // Reset values
    repeat (3) @(posedge clk_i); #1;
    check_val("rst_ack", {31'b0, wb_ack_o}, 32'h0);
    check_val("rst_dat", wb_dat_o, 32'h0);
    check_val("rst_txd", {31'b0, uart_txd_o}, 32'h1);
    check_val("rst_irq", {31'b0, irq_o}, 32'h0);
    rst_i = 1'b0;
    wb_read(8'h04, rd); check_val("rst_status", rd, 32'h60);
    wb_read(8'h08, rd); check_val("rst_level", rd, 32'h0);
    wb_read(8'h0C, rd); check_val("rst_ctrl", rd, 32'h0);
    wb_read(8'h10, rd); check_val("unmapped_rd", rd, 32'h0);

    // Single TX frame 0x55 with stb held across the ack cycle
    @(posedge clk_i); #1;
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = 32'h0; wb_dat_i = 32'h55; wb_sel_i = 4'hF;
    @(posedge clk_i); #1;
    check_val("ack_first", {31'b0, wb_ack_o}, 32'h1);
    @(posedge clk_i); #1;
    check_val("ack_single", {31'b0, wb_ack_o}, 32'h0);
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    check_val("tx_start_low", {31'b0, uart_txd_o}, 32'h0);
    n = 0;
    while (uart_txd_o === 1'b0 && n < 20) begin n++; @(posedge clk_i); #1; end
    check_val("tx_start_len", n, 8);
    wb_read(8'h04, rd); check_val("status_tx_busy", rd, 32'h20);
    wait_frames(1, 200);
    repeat (8) @(posedge clk_i); #1;
    check_val("tx55_frames", tx_q.size(), 1);
    check_val("tx55_byte", {24'h0, tx_q[0]}, 32'h55);
    check_val("tx55_stop", tx_bad_stop, 0);
    check_val("tx55_idle_line", {31'b0, uart_txd_o}, 32'h1);
    wb_read(8'h04, rd); check_val("status_tx_idle", rd, 32'h60);

    // DATA write with sel[0]=0 is ignored
    tx_q.delete(); tx_t.delete();
    wb_xfer(1'b1, 8'h00, 32'h99, 4'hE, rd);
    wb_read(8'h08, rd); check_val("sel0_level", rd, 32'h0);
    repeat (20) @(posedge clk_i); #1;
    check_val("sel0_no_frame", tx_q.size(), 0);

    // Five queued writes, sixth overflows, five back-to-back frames
    for (int i = 0; i < 5; i++) wb_write(8'h00, 32'hA0 + i);
    wb_read(8'h04, rd); check_val("status_tx_full", rd, 32'h00);
    wb_read(8'h08, rd); check_val("level_tx_full", rd, 32'h0400);
    wb_write(8'h00, 32'hEE);
    wb_read(8'h04, rd); check_val("status_tx_ovf", rd, 32'h08);
    wait_frames(5, 700);
    repeat (200) @(posedge clk_i); #1;
    check_val("b2b_frames", tx_q.size(), 5);
    for (int i = 0; i < 5 && i < tx_q.size(); i++)
      check_val($sformatf("b2b_byte%0d", i), {24'h0, tx_q[i]}, 32'hA0 + i);
    for (int i = 0; i < 4 && i + 1 < tx_t.size(); i++)
      check_val($sformatf("b2b_gap%0d", i), tx_t[i+1] - tx_t[i], 80);
    wb_write(8'h0C, 32'h04);
    wb_read(8'h04, rd); check_val("status_ovf_clr", rd, 32'h60);

    // Flush: in-flight frame completes, queued bytes dropped
    tx_q.delete(); tx_t.delete();
    wb_write(8'h00, 32'hB0); wb_write(8'h00, 32'hB1); wb_write(8'h00, 32'hB2);
    wb_write(8'h0C, 32'h08);
    wb_read(8'h08, rd); check_val("flush_level", rd, 32'h0);
    repeat (250) @(posedge clk_i); #1;
    check_val("flush_frames", tx_q.size(), 1);
    if (tx_q.size() > 0) check_val("flush_byte", {24'h0, tx_q[0]}, 32'hB0);

    // RX frame 0xA3
    send_frame(8'hA3, 1'b1);
    wb_read(8'h04, rd); check_val("rx_status", rd, 32'h61);
    wb_read(8'h08, rd); check_val("rx_level", rd, 32'h1);
    wb_read(8'h00, rd); check_val("rx_data", rd, 32'hA3);
    wb_read(8'h04, rd); check_val("rx_status_empty", rd, 32'h60);
    wb_read(8'h00, rd); check_val("rx_empty_read", rd, 32'h0);

    // RX overrun: five frames, four kept
    for (int i = 0; i < 5; i++) send_frame(8'h11 * (i + 1), 1'b1);
    wb_read(8'h08, rd); check_val("ovr_level", rd, 32'h4);
    wb_read(8'h04, rd); check_val("ovr_status", rd, 32'h63);
    check_val("ovr_irq", {31'b0, irq_o}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      wb_read(8'h00, rd); check_val($sformatf("ovr_byte%0d", i), rd, 32'h11 * (i + 1));
    end
    wb_read(8'h08, rd); check_val("ovr_level_drain", rd, 32'h0);
    wb_write(8'h0C, 32'h04);
    wb_read(8'h04, rd); check_val("ovr_clr_status", rd, 32'h60);
    check_val("ovr_clr_irq", {31'b0, irq_o}, 32'h0);

    // Framing error, then glitch rejection, then a clean frame
    send_frame(8'h5A, 1'b0);
    wb_read(8'h04, rd); check_val("ferr_status", rd, 32'h64);
    wb_read(8'h08, rd); check_val("ferr_level", rd, 32'h0);
    check_val("ferr_irq", {31'b0, irq_o}, 32'h1);
    wb_write(8'h0C, 32'h04);
    @(posedge clk_i); #1; uart_rxd_i = 1'b0;
    repeat (3) @(posedge clk_i); #1; uart_rxd_i = 1'b1;
    repeat (20) @(posedge clk_i); #1;
    wb_read(8'h04, rd); check_val("glitch_status", rd, 32'h60);
    wb_read(8'h08, rd); check_val("glitch_level", rd, 32'h0);
    send_frame(8'h3C, 1'b1);
    wb_read(8'h00, rd); check_val("post_glitch_data", rd, 32'h3C);

    // Interrupt enables
    wb_write(8'h0C, 32'h0F);
    wb_read(8'h0C, rd); check_val("ctrl_rb", rd, 32'h3);
    check_val("irq_tx_idle", {31'b0, irq_o}, 32'h1);
    wb_write(8'h0C, 32'h01);
    repeat (2) @(posedge clk_i); #1;
    check_val("irq_rx_en_empty", {31'b0, irq_o}, 32'h0);
    send_frame(8'h7E, 1'b1);
    check_val("irq_rx_ne", {31'b0, irq_o}, 32'h1);
    wb_read(8'h00, rd); check_val("irq_rx_data", rd, 32'h7E);
    repeat (2) @(posedge clk_i); #1;
    check_val("irq_rx_clr", {31'b0, irq_o}, 32'h0);
    wb_write(8'h0C, 32'h00);

    // Reset mid-frame
    wb_write(8'h00, 32'h0F); wb_write(8'h00, 32'h10); wb_write(8'h00, 32'h20);
    repeat (20) @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    check_val("midrst_txd", {31'b0, uart_txd_o}, 32'h1);
    check_val("midrst_irq", {31'b0, irq_o}, 32'h0);
    rst_i = 1'b0;
    wb_read(8'h08, rd); check_val("midrst_level", rd, 32'h0);
    wb_read(8'h04, rd); check_val("midrst_status", rd, 32'h60);
    check_val("midrst_txd_idle", {31'b0, uart_txd_o}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
